// File: rtl/conv_window_engine.sv
// conv_window_engine: sequential 2-D convolution over an IMG_N x IMG_N image with a K x K kernel.
// Each valid window is computed with one multiply-accumulate per cycle, in raster window order.
// Each window result is presented on a valid/ready port.
//
// Optional feature macro: CONV_SAT_EN
//   defined   -> out_data saturates at 2^ACC_W-1
//   undefined -> out_data is the accumulator modulo 2^ACC_W (wrap-around)
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   img_wr_en/addr/data      pixel write port, raster address row*IMG_N+col, accepted only in idle
//   ker_wr_en/addr/data      coefficient write port, raster address row*K+col, accepted only in idle
//   start                    begin a pass (sampled only in idle)
//   busy                     pass in progress (MAC or result-output phase)
//   done                     one-cycle pulse after the final result handshake
//   out_valid/out_ready      result handshake
//   out_data/out_row/out_col window result and its window coordinates
module conv_window_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_N  = 4,
  parameter int unsigned K      = 3,
  parameter int unsigned ACC_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             img_wr_en,
  input  logic [$clog2(IMG_N*IMG_N)-1:0]   img_wr_addr,
  input  logic [DATA_W-1:0]                img_wr_data,
  input  logic                             ker_wr_en,
  input  logic [$clog2(K*K)-1:0]           ker_wr_addr,
  input  logic [DATA_W-1:0]                ker_wr_data,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
  output logic [$clog2(IMG_N-K+1):0]       out_row,
  output logic [$clog2(IMG_N-K+1):0]       out_col
);

  localparam int unsigned NumPix  = IMG_N * IMG_N;
  localparam int unsigned NumCoef = K * K;
  localparam int unsigned NumWin  = IMG_N - K + 1;
  localparam int unsigned PixAw   = $clog2(NumPix);
  localparam int unsigned CoefAw  = $clog2(NumCoef);
  localparam int unsigned WinW    = $clog2(NumWin) + 1;
  localparam int unsigned KW      = $clog2(K) + 1;
  // Wide enough to hold the sum of K*K full-scale products without overflow.
  localparam int unsigned SumW    = 2 * DATA_W + $clog2(NumCoef);

  typedef enum logic [1:0] {StIdle, StMac, StOut, StFin} state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     img_q [NumPix];
  logic [DATA_W-1:0]     ker_q [NumCoef];
  logic [WinW-1:0]       row_q, row_d, col_q, col_d;
  logic [KW-1:0]         kr_q, kr_d, kc_q, kc_d;
  logic [SumW-1:0]       acc_q, acc_d;
  logic [ACC_W-1:0]      out_data_q, out_data_d;

  logic [PixAw-1:0]      img_idx;
  logic [CoefAw-1:0]     ker_idx;
  logic [2*DATA_W-1:0]   prod;
  logic [SumW-1:0]       mac_sum;
  logic [ACC_W-1:0]      mac_res;
  logic                  last_win;

  // Storage is deliberately not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle) begin
      if (img_wr_en && (32'(img_wr_addr) < NumPix)) img_q[img_wr_addr] <= img_wr_data;
      if (ker_wr_en && (32'(ker_wr_addr) < NumCoef)) ker_q[ker_wr_addr] <= ker_wr_data;
    end
  end

  always_comb begin
    img_idx = PixAw'((32'(row_q) + 32'(kr_q)) * IMG_N + 32'(col_q) + 32'(kc_q));
    ker_idx = CoefAw'(32'(kr_q) * K + 32'(kc_q));
    prod    = (2 * DATA_W)'(img_q[img_idx]) * (2 * DATA_W)'(ker_q[ker_idx]);
    mac_sum = acc_q + SumW'(prod);
`ifdef CONV_SAT_EN
    if (mac_sum > SumW'({ACC_W{1'b1}})) mac_res = {ACC_W{1'b1}};
    else                                mac_res = mac_sum[ACC_W-1:0];
`else
    mac_res = mac_sum[ACC_W-1:0];
`endif
    last_win = (row_q == WinW'(NumWin - 1)) && (col_q == WinW'(NumWin - 1));
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
          acc_d   = '0;
        end
      end
      StMac: begin
        acc_d = mac_sum;
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          if (kr_q == KW'(K - 1)) begin
            kr_d       = '0;
            state_d    = StOut;
            out_data_d = mac_res;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (last_win) begin
            state_d = StFin;
          end else begin
            state_d = StMac;
            acc_d   = '0;
            if (col_q == WinW'(NumWin - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy      = (state_q == StMac) || (state_q == StOut);
  assign done      = (state_q == StFin);
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;

endmodule
